// File: rtl/enc_sched_pkg.sv
// Shared types and helpers for the encoded grant scheduler.
// Latency: n/a (types and pure functions). Backpressure: n/a.
// No configuration macros are used here.
package enc_sched_pkg;

    localparam int NREQ = 8;
    localparam int IDXW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Callers guarantee one-hot input; a zero vector maps to index 0.
    function automatic logic [IDXW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDXW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/enc_prio_pick.sv
// Combinational winner pick: first set request scanning downward from a start index.
// Latency: 0 cycles (pure combinational). Backpressure: none, evaluated every cycle.
// WRAP=0 stops the scan at index 0; WRAP=1 continues from NREQ-1 down to start+1.
module enc_prio_pick
    import enc_sched_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] start,
    output logic [IDXW-1:0] pick_idx,
    output logic            pick_vld
);

    logic [IDXW-1:0] cand;

    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = start - IDXW'(i);
            if (!pick_vld && req[cand] && (WRAP || i <= int'(start))) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enc_req_scheduler.sv
// Shares one encoded grant link among 8 requesters: bounded tenure, one-cycle gap.
// Latency: request to grant 1 cycle; minimum 2 dead cycles between tenures.
// Backpressure: owner holds until release, request drop or MAX_HOLD expiry; ENC_REQ_SCHED_RR_EN selects round-robin.
module enc_req_scheduler
    import enc_sched_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] req_in,
    input  logic            EN_release,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDXW-1:0] grant_idx,
    output logic            RDY_grant,
    output logic            timeout_pulse
);

    state_t          state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDXW-1:0] pick_start;
    logic [IDXW-1:0] pick_idx;
    logic            pick_vld;
    logic            owner_req;
    logic            expire;
    logic            grant_exit;

`ifdef ENC_REQ_SCHED_RR_EN
    localparam bit PICK_WRAP = 1'b1;
    logic [IDXW-1:0] rr_ptr;
    assign pick_start = rr_ptr - IDXW'(1);
`else
    localparam bit PICK_WRAP = 1'b0;
    assign pick_start = IDXW'(NREQ - 1);
`endif

    enc_prio_pick #(
        .WRAP (PICK_WRAP)
    ) u_pick (
        .req      (req_in),
        .start    (pick_start),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Owner's request line is looked up through the one-hot register so the
    // drop check follows exactly the grant the consumer sees.
    assign owner_req  = req_in[onehot_to_idx(grant_onehot)];
    assign expire     = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign grant_exit = EN_release || !owner_req || expire;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            grant_onehot  <= '0;
            grant_idx     <= '0;
            RDY_grant     <= 1'b0;
            timeout_pulse <= 1'b0;
            hold_cnt      <= '0;
`ifdef ENC_REQ_SCHED_RR_EN
            rr_ptr        <= IDXW'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    timeout_pulse <= 1'b0;
                    if (pick_vld) begin
                        state        <= GRANT;
                        grant_idx    <= pick_idx;
                        grant_onehot <= NREQ'(1) << pick_idx;
                        RDY_grant    <= 1'b1;
                        hold_cnt     <= '0;
`ifdef ENC_REQ_SCHED_RR_EN
                        rr_ptr       <= pick_idx;
`endif
                    end
                end
                GRANT: begin
                    if (grant_exit) begin
                        state         <= GAP;
                        grant_onehot  <= '0;
                        grant_idx     <= '0;
                        RDY_grant     <= 1'b0;
                        hold_cnt      <= '0;
                        // Release or a dropped request on the expiry edge suppresses the pulse.
                        timeout_pulse <= expire && !EN_release && owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    state         <= IDLE;
                    timeout_pulse <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    grant_onehot  <= '0;
                    grant_idx     <= '0;
                    RDY_grant     <= 1'b0;
                    timeout_pulse <= 1'b0;
                    hold_cnt      <= '0;
                end
            endcase
        end
    end

endmodule
